regfile_writeback: RTL and testbench

Write side of the processor's 8-entry register file. Accepts register-write requests (3-bit register number plus 8-bit data) through a valid/ready handshake and holds them in a small in-order write-back buffer. It retires the buffered writes into the register array one per cycle when the pipeline allows. Two combinational read ports return the architecturally newest value of any register, bypassing from the buffer, and a per-register pending mask feeds hazard detection.

---
 rtl/regfile_writeback.sv | 78 +++++++
 tb/tb_regfile_writeback.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/regfile_writeback.sv
// regfile_writeback: 8-entry register file write side with in-order write-back buffer and bypassing reads
//   clk, rst_n          : clock, asynchronous active-low reset
//   wr_valid/wr_ready   : write request handshake carrying wr_reg, wr_data
//   drain_en            : allows the buffer head to retire into the array this cycle
//   rd_a_reg/rd_a_data  : read port A (newest value, buffer bypass included)
//   rd_b_reg/rd_b_data  : read port B (same as A)
//   pending             : bit r set while any buffered entry targets register r
//   count               : number of buffered entries
module regfile_writeback #(
  parameter int DATA_W = 8,
  parameter int REG_AW = 3,
  parameter int DEPTH  = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [REG_AW-1:0]       wr_reg,
  input  logic [DATA_W-1:0]       wr_data,
  input  logic                    drain_en,
  input  logic [REG_AW-1:0]       rd_a_reg,
  output logic [DATA_W-1:0]       rd_a_data,
  input  logic [REG_AW-1:0]       rd_b_reg,
  output logic [DATA_W-1:0]       rd_b_data,
  output logic [2**REG_AW-1:0]    pending,
  output logic [$clog2(DEPTH):0]  count
);
  localparam int PW = $clog2(DEPTH);
  localparam int NR = 2**REG_AW;
  logic [PW:0] head, tail;
  logic [PW-1:0] hidx, tidx, slot;
  logic [REG_AW-1:0] ent_reg [DEPTH];
  logic [DATA_W-1:0] ent_data [DEPTH];
  logic [DATA_W-1:0] regs [NR];
  logic enq, deq;
  assign hidx = head[PW-1:0];
  assign tidx = tail[PW-1:0];
  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  // Entries are scanned oldest to newest, so the last match is the youngest.
  always_comb begin
    count = tail - head;
    wr_ready = count != (PW+1)'(DEPTH);
    enq = wr_valid && wr_ready;
    deq = drain_en && count != '0;
    pending = '0;
    rd_a_data = regs[rd_a_reg];
    rd_b_data = regs[rd_b_reg];
    slot = hidx;
    for (int k = 0; k < DEPTH; k++) begin
      slot = hidx + PW'(k);
      if ((PW+1)'(k) < count) begin
        pending[ent_reg[slot]] = 1'b1;
        if (ent_reg[slot] == rd_a_reg) rd_a_data = ent_data[slot];
        if (ent_reg[slot] == rd_b_reg) rd_b_data = ent_data[slot];
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
      for (int i = 0; i < NR; i++) regs[i] <= '0;
    end else begin
      if (enq) tail <= tail + (PW+1)'(1);
      if (deq) begin
        head <= head + (PW+1)'(1);
        regs[ent_reg[hidx]] <= ent_data[hidx];
      end
    end
  end
  // Buffer payload needs no reset: occupancy alone decides which slots are live.
  always_ff @(posedge clk) begin
    if (enq) begin
      ent_reg[tidx] <= wr_reg;
      ent_data[tidx] <= wr_data;
    end
  end
endmodule

// File: tb/tb_regfile_writeback.sv
// tb_regfile_writeback: scoreboard bench for regfile_writeback against a queue-based reference model
module tb_regfile_writeback;
  localparam int DEPTH = 2;
  logic clk = 0;
  logic rst_n = 0;
  logic wr_valid = 0;
  logic wr_ready;
  logic [2:0] wr_reg = 0;
  logic [7:0] wr_data = 0;
  logic drain_en = 0;
  logic [2:0] rd_a_reg = 0;
  logic [7:0] rd_a_data;
  logic [2:0] rd_b_reg = 0;
  logic [7:0] rd_b_data;
  logic [7:0] pending;
  logic [1:0] count;
  int total = 0;
  int bad = 0;
  regfile_writeback #(.DATA_W(8), .REG_AW(3), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_reg(wr_reg), .wr_data(wr_data), .drain_en(drain_en),
    .rd_a_reg(rd_a_reg), .rd_a_data(rd_a_data),
    .rd_b_reg(rd_b_reg), .rd_b_data(rd_b_data),
    .pending(pending), .count(count)
  );
  always #5 clk = ~clk;
  typedef struct packed { logic [2:0] r; logic [7:0] d; } ent_t;
  typedef struct packed { logic [1:0] cnt; logic [7:0] pend; logic rdy; logic [7:0] a; logic [7:0] b; } exp_t;
  ent_t mq[$];
  logic [7:0] mregs [8];
  exp_t exp_q[$];
  string name_q[$];
  function automatic logic [7:0] mread(logic [2:0] a);
    logic [7:0] v = mregs[a];
    foreach (mq[i]) if (mq[i].r == a) v = mq[i].d;
    return v;
  endfunction
  task automatic mclear();
    foreach (mregs[i]) mregs[i] = 8'h00;
    mq.delete();
  endtask
  task automatic model_edge();
    bit acc, drn;
    ent_t e;
    if (rst_n) begin
      acc = wr_valid && mq.size() < DEPTH;
      drn = drain_en && mq.size() > 0;
      if (drn) begin
        e = mq.pop_front();
        mregs[e.r] = e.d;
      end
      if (acc) mq.push_back('{r: wr_reg, d: wr_data});
    end
  endtask
  task automatic push_exp(input string nm);
    exp_t e;
    e.cnt = 2'(mq.size());
    e.pend = '0;
    foreach (mq[i]) e.pend[mq[i].r] = 1'b1;
    e.rdy = mq.size() < DEPTH;
    e.a = mread(rd_a_reg);
    e.b = mread(rd_b_reg);
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask
  task automatic step(input logic v, input logic [2:0] r, input logic [7:0] d, input logic dr,
                      input logic [2:0] ra, input logic [2:0] rb, input string nm);
    @(posedge clk);
    model_edge();
    #1;
    wr_valid = v;
    wr_reg = r;
    wr_data = d;
    drain_en = dr;
    rd_a_reg = ra;
    rd_b_reg = rb;
    push_exp(nm);
  endtask
  function automatic void chk(string n, string f, int act, int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s.%s got=%0h want=%0h", n, f, act, req);
    end
  endfunction
  always @(negedge clk) begin
    exp_t e;
    string n;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      chk(n, "count", int'(count), int'(e.cnt));
      chk(n, "pending", int'(pending), int'(e.pend));
      chk(n, "wr_ready", int'(wr_ready), int'(e.rdy));
      chk(n, "rd_a", int'(rd_a_data), int'(e.a));
      chk(n, "rd_b", int'(rd_b_data), int'(e.b));
    end
  end
  initial begin
    mclear();
    step(0, 0, 0, 0, 0, 0, "in_reset");
    @(posedge clk);
    #1 rst_n = 1;
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 3'(i), 3'(7 - i), "reset_read");
    step(1, 3, 8'h5A, 0, 3, 3, "w_r3_5a");
    step(1, 3, 8'hA5, 0, 3, 1, "w_r3_a5");
    step(1, 1, 8'h11, 0, 3, 1, "full_refuse");
    step(0, 0, 0, 0, 3, 1, "after_refuse");
    step(0, 0, 0, 1, 3, 3, "drain_start");
    step(0, 0, 0, 1, 3, 3, "drain_1");
    step(0, 0, 0, 0, 3, 3, "drain_2");
    for (int i = 0; i < 8; i++) step(1, 3'(i), 8'(8'h10 + i), 1, 3'(i), 3'(i), "stream");
    step(0, 0, 0, 1, 6, 7, "stream_tail");
    step(0, 0, 0, 0, 6, 7, "stream_done");
    step(1, 2, 8'h33, 0, 2, 4, "fill_r2");
    step(1, 4, 8'h44, 0, 2, 4, "fill_r4");
    step(1, 5, 8'h99, 1, 2, 5, "full_enq_drain");
    step(1, 5, 8'h55, 1, 4, 5, "enq_with_drain");
    step(0, 0, 0, 0, 5, 4, "count_steady");
    step(0, 0, 0, 1, 5, 2, "empty_out");
    step(1, 6, 8'h77, 0, 6, 6, "w_r6_77");
    step(0, 0, 0, 0, 6, 6, "r6_buffered");
    @(posedge clk);
    model_edge();
    #1;
    rst_n = 0;
    mclear();
    push_exp("reset_mid");
    @(posedge clk);
    #1 rst_n = 1;
    step(0, 0, 0, 0, 6, 6, "after_reset");
    step(0, 0, 0, 1, 6, 0, "drain_empty");
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 2) != 0), 3'($urandom), 8'($urandom),
           1'($urandom_range(0, 2) != 0), 3'($urandom), 3'($urandom), "random");
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("end", "queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
